message_writer: RTL and testbench

- Write side of the 16-entry, 4-bit message memory that the 7-segment rotating display reads.
- Takes a 4-bit character code from the switches and a write push-button, and stores the code at the next free slot.
- A clear push-button refills the whole memory with the blank code.
- The display logic reads the memory through a combinational read port. The block runs in the same clock domain as the display, fed from the MMCM output clock.

---
 rtl/message_writer_if.sv | 39 +++
 rtl/message_writer.sv | 171 +++++++++++++++++
 tb/tb_message_writer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/message_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : message_writer_if
//  Description : Bus bundle between the message writer and its environment.
//                master drives switches, buttons and the display read
//                address; slave (the writer) returns read data and status.
//  Signals     : data_in[3:0]   character code from switches
//                button_write   raw write push-button
//                button_clear   raw clear push-button
//                rd_addr[3:0]   display read address
//                rd_data[3:0]   mem[rd_addr], combinational
//                count[4:0]     number of stored characters, 0..16
//                full           count == 16
//                busy           writer in WRITE or CLEAR
//                write_pulse    one-cycle strobe per committed character
//  Revision    : 1.0 - initial release
// ============================================================================
interface message_writer_if;
    logic [3:0] data_in;
    logic       button_write;
    logic       button_clear;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       busy;
    logic       write_pulse;

    modport master (
        output data_in, button_write, button_clear, rd_addr,
        input  rd_data, count, full, busy, write_pulse
    );

    modport slave (
        input  data_in, button_write, button_clear, rd_addr,
        output rd_data, count, full, busy, write_pulse
    );
endinterface
`default_nettype wire

// File: rtl/message_writer.sv
`default_nettype none
// ============================================================================
//  Module      : message_writer
//  Description : Write side of the 16 x 4-bit message memory read by the
//                rotating 7-segment display. Debounced write button appends
//                the switch code at the next free slot; debounced clear
//                button refills the memory with BLANK_CODE over 16 cycles.
//  Ports       : clk    system clock (MMCM output)
//                reset  asynchronous, active-low reset
//                bus    message_writer_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module message_writer #(
    parameter int         DEBOUNCE_COUNT = 250000,
    parameter int         CNT_W          = 18,
    parameter logic [3:0] BLANK_CODE     = 4'hF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    message_writer_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [4:0]       c_full_cnt = 5'd16;
    localparam int               c_btn_wr   = 0;
    localparam int               c_btn_clr  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_latch_wr;
    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic [3:0] r_wr_data;
    logic [3:0] r_clr_addr;
    logic [4:0] r_count;
    logic [3:0] r_mem [16];
    logic       w_full;

    assign w_raw = {bus.button_clear, bus.button_write};

    // ------------------------------------------------------------------
    // Per-button 2-flop synchronizer + debounce. The press event is raised
    // in the cycle whose edge flips the accepted level from 0 to 1, so the
    // FSM acts on the same edge that accepts the new level.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]       r_sync;
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync  <= 2'b00;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    if (r_sync[1] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_sync[1] && !r_level && (r_cnt == c_cnt_last);
        end
    endgenerate

    assign w_full = (r_count == c_full_cnt);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Clear has priority over write; presses seen outside IDLE are dropped.
    always_comb begin
        w_next_state = r_state;
        w_latch_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[c_btn_clr]) begin
                    w_next_state = ST_CLEAR;
                end else if (w_press[c_btn_wr] && !w_full) begin
                    w_next_state = ST_WRITE;
                    w_latch_wr   = 1'b1;
                end
            end
            ST_WRITE: begin
                w_next_state = ST_IDLE;
            end
            ST_CLEAR: begin
                if (r_clr_addr == 4'hF) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: write data latch, clear address, character count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_data  <= 4'h0;
            r_clr_addr <= 4'h0;
            r_count    <= 5'd0;
        end else begin
            if (w_latch_wr) begin
                r_wr_data <= bus.data_in;
            end
            if (r_state == ST_IDLE) begin
                r_clr_addr <= 4'h0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 4'h1;
            end
            // WRITE is only entered when not full, so count never exceeds 16.
            if (r_state == ST_WRITE) begin
                r_count <= r_count + 5'd1;
            end else if ((r_state == ST_CLEAR) && (r_clr_addr == 4'hF)) begin
                r_count <= 5'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Message memory
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= BLANK_CODE;
            end
        end else begin
            if (r_state == ST_WRITE) begin
                r_mem[r_count[3:0]] <= r_wr_data;
            end else if (r_state == ST_CLEAR) begin
                r_mem[r_clr_addr] <= BLANK_CODE;
            end
        end
    end

    // Read port shows the pre-edge contents during a write to the same slot.
    assign bus.rd_data     = r_mem[bus.rd_addr];
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.write_pulse = (r_state == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_message_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_message_writer
//  Description : Directed self-checking bench for message_writer with
//                DEBOUNCE_COUNT = 4. Inputs change 1 time unit after the
//                rising edge; outputs are sampled there or after the
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_message_writer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_pulses;

    message_writer_if bus ();

    message_writer #(
        .DEBOUNCE_COUNT (4),
        .CNT_W          (18),
        .BLANK_CODE     (4'hF)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.write_pulse === 1'b1) begin
            n_pulses <= n_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag, input int addr, input logic [3:0] exp);
        @(negedge clk);
        bus.rd_addr = addr[3:0];
        #1;
        check($sformatf("%s_mem%0d", tag, addr), {28'd0, bus.rd_data}, {28'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic press_write(input logic [3:0] d);
        bus.data_in      = d;
        bus.button_write = 1'b1;
        repeat (10) tick();
        bus.button_write = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int lat;
        int p0;
        int busy_cycles;

        n_tests = 0;
        n_fail  = 0;
        n_pulses = 0;
        reset = 1'b1;
        bus.data_in      = 4'h0;
        bus.button_write = 1'b0;
        bus.button_clear = 1'b0;
        bus.rd_addr      = 4'h0;

        // ---- Reset state ----
        do_reset();
        for (int i = 0; i < 16; i++) check_mem("rst", i, 4'hF);
        check("rst_count", {27'd0, bus.count}, 32'd0);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_pulse", {31'd0, bus.write_pulse}, 32'd0);

        // ---- Clean write: pulse 6 edges after the raw edge ----
        tick();
        p0 = n_pulses;
        bus.data_in      = 4'h3;
        bus.button_write = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.write_pulse === 1'b1 && lat == 0) begin
                lat = n;
                bus.data_in = 4'h7;   // later switch changes must not matter
            end
        end
        bus.button_write = 1'b0;
        repeat (10) tick();
        check("clean_latency", lat, 32'd6);
        check("clean_pulses", n_pulses - p0, 32'd1);
        check_mem("clean", 0, 4'h3);
        check("clean_count", {27'd0, bus.count}, 32'd1);

        // ---- Bouncing write: one pulse only after stable level ----
        p0 = n_pulses;
        bus.data_in = 4'h5;
        for (int k = 0; k < 3; k++) begin
            bus.button_write = 1'b1;
            repeat (2) tick();
            bus.button_write = 1'b0;
            repeat (2) tick();
        end
        check("bounce_no_early", n_pulses - p0, 32'd0);
        press_write(4'h5);
        check("bounce_pulses", n_pulses - p0, 32'd1);
        check("bounce_count", {27'd0, bus.count}, 32'd2);
        check_mem("bounce", 1, 4'h5);

        // ---- Fill to 16, then a 17th press is dropped ----
        do_reset();
        for (int i = 0; i < 16; i++) press_write(i[3:0]);
        check("fill_count", {27'd0, bus.count}, 32'd16);
        check("fill_full", {31'd0, bus.full}, 32'd1);
        p0 = n_pulses;
        press_write(4'hA);
        check("full_no_pulse", n_pulses - p0, 32'd0);
        check("full_count", {27'd0, bus.count}, 32'd16);
        for (int i = 0; i < 16; i++) check_mem("fill", i, i[3:0]);

        // ---- Simultaneous write+clear: clear wins, write during CLEAR dropped ----
        do_reset();
        for (int i = 0; i < 5; i++) press_write(4'(i + 1));
        check("pre_clr_count", {27'd0, bus.count}, 32'd5);
        p0 = n_pulses;
        busy_cycles = 0;
        bus.button_write = 1'b1;
        bus.button_clear = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (bus.busy === 1'b1) busy_cycles++;
            if (n == 7) begin
                bus.button_write = 1'b0;
                bus.button_clear = 1'b0;
            end
            if (n == 13) bus.button_write = 1'b1;
            if (n == 30) bus.button_write = 1'b0;
        end
        check("clr_busy_cycles", busy_cycles, 32'd16);
        check("clr_no_pulse", n_pulses - p0, 32'd0);
        check("clr_count", {27'd0, bus.count}, 32'd0);
        check("clr_busy_end", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("clr", i, 4'hF);

        // ---- Reset in the 7th CLEAR cycle aborts immediately ----
        do_reset();
        for (int i = 0; i < 5; i++) press_write(4'(i + 1));
        bus.button_clear = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 7) bus.button_clear = 1'b0;
        end
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_count", {27'd0, bus.count}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("abort", i, 4'hF);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        press_write(4'h9);
        check_mem("after_abort", 0, 4'h9);
        check("after_abort_count", {27'd0, bus.count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
